// File: rtl/apb_initiator.sv
// apb_initiator: single-command APB initiator with per-access wait timeout and one-cycle completion pulse
module apb_initiator #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic       ini_clk,
    input  logic       ini_reset,
    input  logic       ini_cmd_valid,
    output logic       ini_cmd_ready,
    input  logic       ini_cmd_write,
    input  logic [7:0] ini_cmd_addr,
    input  logic [7:0] ini_cmd_wdata,
    output logic       ini_rsp_valid,
    output logic [7:0] ini_rsp_rdata,
    output logic       ini_rsp_timeout,
    output logic       ini_psel,
    output logic       ini_penable,
    output logic       ini_pwrite,
    output logic [7:0] ini_paddr,
    output logic [7:0] ini_pwdata,
    input  logic [7:0] ini_prdata,
    input  logic       ini_pready
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       to_hit;
    logic       finish;
    assign to_hit = (TIMEOUT_CYCLES != 8'd0) && ({1'b0, wait_cnt} + 9'd1 == {1'b0, TIMEOUT_CYCLES});
    assign finish = (state == ACCESS) && (ini_pready || to_hit);
    // state register; reset wins over everything, aborting any transfer in flight
    always_ff @(posedge ini_clk) begin
        state <= ini_reset ? IDLE : state_nxt;
    end
    // next-state and bus/handshake strobes decoded from the current phase
    always_comb begin
        state_nxt     = state;
        ini_cmd_ready = 1'b0;
        ini_psel      = 1'b0;
        ini_penable   = 1'b0;
        ini_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                ini_cmd_ready = !ini_reset;
                state_nxt     = ini_cmd_valid ? SETUP : IDLE;
            end
            SETUP: begin
                ini_psel  = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                ini_psel    = 1'b1;
                ini_penable = 1'b1;
                state_nxt   = finish ? DONE : ACCESS;
            end
            DONE: begin
                ini_rsp_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // command capture, wait counting and response capture; bus fields hold between transfers
    always_ff @(posedge ini_clk) begin
        if (ini_reset) begin
            ini_pwrite      <= 1'b0;
            ini_paddr       <= 8'h00;
            ini_pwdata      <= 8'h00;
            ini_rsp_rdata   <= 8'h00;
            ini_rsp_timeout <= 1'b0;
            wait_cnt        <= 8'h00;
        end else begin
            if (state == IDLE && ini_cmd_valid) begin
                ini_pwrite <= ini_cmd_write;
                ini_paddr  <= ini_cmd_addr;
                ini_pwdata <= ini_cmd_wdata;
            end
            if (state == SETUP)
                wait_cnt <= 8'h00;
            else if (state == ACCESS && !ini_pready)
                wait_cnt <= wait_cnt + 8'd1;
            if (finish) begin
                ini_rsp_rdata   <= (ini_pready && !ini_pwrite) ? ini_prdata : 8'h00;
                ini_rsp_timeout <= !ini_pready;
            end
        end
    end
endmodule
